btb_write_arbiter: RTL and testbench
====================================

Name: btb_write_arbiter

Overview:
- Parametrised successor to the branch-target-buffer write path. Arbitrates up to WRITE_NUM update requests per cycle onto WRITE_NUM ports of a BANK_NUM-bank RAM.
- Bank-conflicting requests are deferred into a multi-entry FIFO. The FIFO accepts several pushes per cycle and drains several entries per cycle.
- Per-index write order is preserved. A built-in init sequencer clears the whole table.
- Sits between execute-stage branch resolution and the BTB entry array.

Parameters:
WRITE_NUM, 2, request ports and RAM write ports
BANK_NUM, 2, RAM banks; bank = index[log2(BANK_NUM)-1:0]; power of two, >= WRITE_NUM
INDEX_WIDTH, 10, table index bits; table holds 2^INDEX_WIDTH entries
DATA_WIDTH, 32, entry payload bits
QUEUE_DEPTH, 4, deferral FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
init_start  in  1  restart the clear sequence (synchronous pulse)
req_valid  in  WRITE_NUM  per-port write request
req_index  in  WRITE_NUM*INDEX_WIDTH  per-port index
req_data  in  WRITE_NUM*DATA_WIDTH  per-port payload
ram_we  out  WRITE_NUM  RAM write enables
ram_wa  out  WRITE_NUM*INDEX_WIDTH  RAM write addresses
ram_wv  out  WRITE_NUM*DATA_WIDTH  RAM write data
init_busy  out  1  clear sequence in progress
queue_count  out  log2(QUEUE_DEPTH)+1  FIFO occupancy
drop_pulse  out  1  at least one request discarded this cycle

Behaviour:
- Reset (rst=0):
  - State INIT, init_ptr=0, FIFO empty (head=tail=count=0).
  - ram_we=0, init_busy=1, drop_pulse=0.
- FSM states:
  - INIT: each cycle writes data 0 to indices init_ptr..init_ptr+WRITE_NUM-1, one per port.
  - INIT: init_ptr advances by WRITE_NUM; moves to RUN after the write covering index 2^INDEX_WIDTH-1.
  - INIT: all req_valid are discarded (drop_pulse=1 if any valid). FIFO is held empty.
  - RUN: init_busy=0; normal arbitration.
  - init_start in any state: next cycle INIT, init_ptr=0, FIFO flushed. Contents in flight are lost; no drop_pulse for flushed entries.
- Arbitration (RUN, combinational; ram_* are valid the same cycle):
  - Step 1, drain: examine FIFO entries from head in order. Grant each while a port is free and its bank is unclaimed.
  - Stop at the first entry that cannot be granted, so FIFO order is kept. At most WRITE_NUM entries drain per cycle.
  - Step 2, new requests in ascending port order. Grant a request iff a port is free, its bank is unclaimed, and its index matches no FIFO entry still resident after step 1.
  - Each grant takes the lowest free output port and claims its bank.
- Enqueue:
  - Every valid, non-granted new request is pushed in ascending port order into free slots. Free slots = QUEUE_DEPTH - count + drained-this-cycle.
  - Requests beyond free space are discarded and drop_pulse=1.
- FIFO update on clock:
  - count_next = count - drained + pushed.
  - head/tail wrap modulo QUEUE_DEPTH.
  - Simultaneous full pop and push is legal.
- queue_count and drop_pulse are combinational from the current state and inputs.
- Two new requests with the same index in one cycle share a bank: the lower port writes, the higher port is queued. Write order is preserved.

Optional Feature:
- Macro BTB_WRITE_ARBITER_COALESCE_EN.
- Defined: a new request whose index matches a resident FIFO entry overwrites that entry's data in place (youngest match). No push, no slot consumed. Several same-cycle matches apply in port order, so the last one wins.
- Undefined: such requests are pushed as separate entries, per the enqueue rule above.

Test Plan:
1. Release rst with WRITE_NUM=2, INDEX_WIDTH=4 -> 8 cycles of ram_we=2'b11 with addresses (0,1),(2,3)..(14,15) and data 0; init_busy falls after the 8th cycle; req_valid during INIT gives drop_pulse=1.
2. RUN, ports 0/1 write idx 4 and 6 (both bank 0) -> idx 4 written on port 0; idx 6 queued (count=1); next cycle with no requests it drains (ram_wa[0]=6, count=0).
3. FIFO holds idx 2; new request idx 2 data 0xB on port 0 while head idx 2 drains -> old data written, new request queued (not coalesced); next cycle 0xB written.
4. Fill FIFO to 4 entries, all bank 0; two bank-0 requests -> head drains, one request pushed, one dropped with drop_pulse=1; count stays 4.
5. init_start asserted while count=3 -> next cycle INIT, count=0, init_ptr=0, no writes of the queued entries.
6. With BTB_WRITE_ARBITER_COALESCE_EN defined: FIFO holds idx 8 data 0x1 behind a blocked head; request idx 8 data 0x2 -> count unchanged, later drain writes 0x2.

Source files
------------

// File: rtl/btb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btb_write_arbiter
// Brief    : Arbitrates WRITE_NUM BTB update requests per cycle onto WRITE_NUM
//            ports of a BANK_NUM-bank entry RAM. Bank-conflicting requests are
//            deferred into a multi-push / multi-pop FIFO that preserves
//            per-index write order. A built-in sequencer clears the table.
// Options  : BTB_WRITE_ARBITER_COALESCE_EN - a request whose index matches a
//            resident FIFO entry overwrites that entry's data in place.
// Revision : 1.0 - initial release
// ============================================================================
module btb_write_arbiter #(
    parameter int WRITE_NUM   = 2,
    parameter int BANK_NUM    = 2,
    parameter int INDEX_WIDTH = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              init_start,
    input  logic [WRITE_NUM-1:0]              req_valid,
    input  logic [WRITE_NUM*INDEX_WIDTH-1:0]  req_index,
    input  logic [WRITE_NUM*DATA_WIDTH-1:0]   req_data,
    output logic [WRITE_NUM-1:0]              ram_we,
    output logic [WRITE_NUM*INDEX_WIDTH-1:0]  ram_wa,
    output logic [WRITE_NUM*DATA_WIDTH-1:0]   ram_wv,
    output logic                              init_busy,
    output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
    output logic                              drop_pulse
);

    localparam int c_QPTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W  = c_QPTR_W + 1;
    localparam int c_BANK_W = $clog2(BANK_NUM);
    localparam int c_PORT_W = $clog2(WRITE_NUM + 1);
    localparam logic [INDEX_WIDTH-1:0] c_LAST_PTR = INDEX_WIDTH'((1 << INDEX_WIDTH) - WRITE_NUM);
    localparam logic [INDEX_WIDTH-1:0] c_PTR_STEP = INDEX_WIDTH'(WRITE_NUM);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } arbState_t;

    arbState_t               r_state;
    logic [INDEX_WIDTH-1:0]  r_initPtr;
    logic [INDEX_WIDTH-1:0]  r_qIndex [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]   r_qData  [QUEUE_DEPTH];
    logic [c_QPTR_W-1:0]     r_head;
    logic [c_QPTR_W-1:0]     r_tail;
    logic [c_CNT_W-1:0]      r_count;

    logic [INDEX_WIDTH-1:0]  w_qIndexNext [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]   w_qDataNext  [QUEUE_DEPTH];
    logic [BANK_NUM-1:0]     w_bankClaimed;
    logic [c_PORT_W-1:0]     w_grantCnt;
    logic [c_CNT_W-1:0]      w_drained;
    logic [c_CNT_W-1:0]      w_pushCnt;
    logic [c_CNT_W-1:0]      w_free;
    logic [c_QPTR_W-1:0]     w_slot;
    logic [c_BANK_W-1:0]     w_bank;
    logic [INDEX_WIDTH-1:0]  w_reqIdx;
    logic [DATA_WIDTH-1:0]   w_reqData;
    logic                    w_stop;
    logic                    w_match;
    logic                    w_drop;
`ifdef BTB_WRITE_ARBITER_COALESCE_EN
    logic [c_QPTR_W-1:0]     w_matchSlot;
`endif

    // Same-cycle arbitration: clear writes in INIT; FIFO drain then new requests in RUN.
    always_comb begin
        ram_we        = '0;
        ram_wa        = '0;
        ram_wv        = '0;
        w_qIndexNext  = r_qIndex;
        w_qDataNext   = r_qData;
        w_bankClaimed = '0;
        w_grantCnt    = '0;
        w_drained     = '0;
        w_pushCnt     = '0;
        w_free        = c_CNT_W'(QUEUE_DEPTH) - r_count;
        w_slot        = '0;
        w_bank        = '0;
        w_reqIdx      = '0;
        w_reqData     = '0;
        w_stop        = 1'b0;
        w_match       = 1'b0;
        w_drop        = 1'b0;
`ifdef BTB_WRITE_ARBITER_COALESCE_EN
        w_matchSlot   = '0;
`endif
        if (r_state == S_INIT) begin
            // Writes are held off while reset is asserted.
            if (rst) begin
                for (int p = 0; p < WRITE_NUM; p++) begin
                    ram_we[p] = 1'b1;
                    ram_wa[p*INDEX_WIDTH +: INDEX_WIDTH] = r_initPtr + INDEX_WIDTH'(p);
                end
                w_drop = |req_valid;
            end
        end else begin
            // Drain from head in order; the first blocked entry stops the drain.
            for (int k = 0; k < WRITE_NUM; k++) begin
                w_slot = r_head + c_QPTR_W'(k);
                w_bank = r_qIndex[w_slot][c_BANK_W-1:0];
                if (!w_stop && (c_CNT_W'(k) < r_count) && !w_bankClaimed[w_bank]) begin
                    for (int o = 0; o < WRITE_NUM; o++) begin
                        if (w_grantCnt == c_PORT_W'(o)) begin
                            ram_we[o] = 1'b1;
                            ram_wa[o*INDEX_WIDTH +: INDEX_WIDTH] = r_qIndex[w_slot];
                            ram_wv[o*DATA_WIDTH +: DATA_WIDTH]   = r_qData[w_slot];
                        end
                    end
                    w_bankClaimed[w_bank] = 1'b1;
                    w_grantCnt = w_grantCnt + c_PORT_W'(1);
                    w_drained  = w_drained + c_CNT_W'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
            w_free = c_CNT_W'(QUEUE_DEPTH) - r_count + w_drained;

            // New requests in port order; an index still resident must wait behind it.
            for (int p = 0; p < WRITE_NUM; p++) begin
                w_reqIdx  = req_index[p*INDEX_WIDTH +: INDEX_WIDTH];
                w_reqData = req_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_bank    = w_reqIdx[c_BANK_W-1:0];
                w_match   = 1'b0;
                for (int j = 0; j < QUEUE_DEPTH; j++) begin
                    w_slot = r_head + c_QPTR_W'(j);
                    if ((c_CNT_W'(j) >= w_drained) && (c_CNT_W'(j) < r_count) &&
                        (r_qIndex[w_slot] == w_reqIdx)) begin
                        w_match = 1'b1;
`ifdef BTB_WRITE_ARBITER_COALESCE_EN
                        w_matchSlot = w_slot;
`endif
                    end
                end
                if (req_valid[p]) begin
                    if ((w_grantCnt < c_PORT_W'(WRITE_NUM)) && !w_bankClaimed[w_bank] && !w_match) begin
                        for (int o = 0; o < WRITE_NUM; o++) begin
                            if (w_grantCnt == c_PORT_W'(o)) begin
                                ram_we[o] = 1'b1;
                                ram_wa[o*INDEX_WIDTH +: INDEX_WIDTH] = w_reqIdx;
                                ram_wv[o*DATA_WIDTH +: DATA_WIDTH]   = w_reqData;
                            end
                        end
                        w_bankClaimed[w_bank] = 1'b1;
                        w_grantCnt = w_grantCnt + c_PORT_W'(1);
`ifdef BTB_WRITE_ARBITER_COALESCE_EN
                    end else if (w_match) begin
                        // Youngest matching entry takes the newer payload.
                        w_qDataNext[w_matchSlot] = w_reqData;
`endif
                    end else if (w_pushCnt < w_free) begin
                        w_slot = r_tail + c_QPTR_W'(w_pushCnt);
                        w_qIndexNext[w_slot] = w_reqIdx;
                        w_qDataNext[w_slot]  = w_reqData;
                        w_pushCnt = w_pushCnt + c_CNT_W'(1);
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
        end
    end

    // Control state: clear sequencer, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_INIT;
            r_initPtr <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else if (init_start) begin
            r_state   <= S_INIT;
            r_initPtr <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else if (r_state == S_INIT) begin
            r_initPtr <= r_initPtr + c_PTR_STEP;
            if (r_initPtr == c_LAST_PTR) begin
                r_state <= S_RUN;
            end
        end else begin
            r_head  <= r_head + c_QPTR_W'(w_drained);
            r_tail  <= r_tail + c_QPTR_W'(w_pushCnt);
            r_count <= r_count - w_drained + w_pushCnt;
        end
    end

    // FIFO payload storage; only pointers/count need reset since count gates every read.
    always_ff @(posedge clk) begin
        if ((r_state == S_RUN) && !init_start) begin
            r_qIndex <= w_qIndexNext;
            r_qData  <= w_qDataNext;
        end
    end

    assign init_busy   = (r_state == S_INIT);
    assign queue_count = r_count;
    assign drop_pulse  = w_drop;

endmodule
`default_nettype wire

// File: tb/tb_btb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_btb_write_arbiter
// Brief    : Self-checking bench for btb_write_arbiter (WRITE_NUM=2,
//            BANK_NUM=2, INDEX_WIDTH=4, QUEUE_DEPTH=4). Expected RAM writes
//            are queued as stimulus is driven and popped as the DUT writes.
//            Honours BTB_WRITE_ARBITER_COALESCE_EN for the coalescing case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_write_arbiter;

    localparam int WN = 2;
    localparam int BN = 2;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int QD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init_start = 1'b0;
    logic [WN-1:0]     req_valid = '0;
    logic [WN*IW-1:0]  req_index = '0;
    logic [WN*DW-1:0]  req_data = '0;
    logic [WN-1:0]     ram_we;
    logic [WN*IW-1:0]  ram_wa;
    logic [WN*DW-1:0]  ram_wv;
    logic              init_busy;
    logic [$clog2(QD):0] queue_count;
    logic              drop_pulse;

    typedef struct {
        int            port;
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expQ[$];
    int  checkCount = 0;
    int  failCount  = 0;

    btb_write_arbiter #(
        .WRITE_NUM   (WN),
        .BANK_NUM    (BN),
        .INDEX_WIDTH (IW),
        .DATA_WIDTH  (DW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_start  (init_start),
        .req_valid   (req_valid),
        .req_index   (req_index),
        .req_data    (req_data),
        .ram_we      (ram_we),
        .ram_wa      (ram_wa),
        .ram_wv      (ram_wv),
        .init_busy   (init_busy),
        .queue_count (queue_count),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expWrite(input int port, input logic [IW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.port = port;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic setReq(input logic [1:0] v, input logic [IW-1:0] i0, input logic [DW-1:0] d0,
                          input logic [IW-1:0] i1, input logic [DW-1:0] d1);
        req_valid = v;
        req_index = {i1, i0};
        req_data  = {d1, d0};
    endtask

    // Samples at the falling edge and scores every active write port against the queue.
    task automatic sampleCycle();
        wr_t e;
        @(negedge clk);
        for (int p = 0; p < WN; p++) begin
            if (ram_we[p]) begin
                checkVal("write_expected", 64'(expQ.size() > 0), 64'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkVal("write_port", 64'(p), 64'(e.port));
                    checkVal("write_addr", 64'(ram_wa[p*IW +: IW]), 64'(e.addr));
                    checkVal("write_data", 64'(ram_wv[p*DW +: DW]), 64'(e.data));
                end
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One RUN cycle: drive, score writes, check occupancy and drop flag.
    task automatic runCycle(input logic [1:0] v, input logic [IW-1:0] i0, input logic [DW-1:0] d0,
                            input logic [IW-1:0] i1, input logic [DW-1:0] d1,
                            input int expCount, input logic expDrop);
        setReq(v, i0, d0, i1, d1);
        sampleCycle();
        checkVal("queue_count", 64'(queue_count), 64'(expCount));
        checkVal("drop_pulse", 64'(drop_pulse), 64'(expDrop));
        checkVal("init_busy_run", 64'(init_busy), 64'd0);
        nextCycle();
    endtask

    task automatic initPhase(input logic [1:0] firstValid);
        for (int c = 0; c < (1 << IW) / WN; c++) begin
            expWrite(0, IW'(2 * c), '0);
            expWrite(1, IW'(2 * c + 1), '0);
        end
        for (int c = 0; c < (1 << IW) / WN; c++) begin
            setReq((c == 0) ? firstValid : 2'b00, 4'd3, 32'h33, 4'd5, 32'h55);
            sampleCycle();
            checkVal("init_busy", 64'(init_busy), 64'd1);
            checkVal("init_count", 64'(queue_count), 64'd0);
            checkVal("init_drop", 64'(drop_pulse), 64'(c == 0 ? |firstValid : 1'b0));
            nextCycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset: requests present but outputs must stay quiet.
        setReq(2'b11, 4'd1, 32'h1, 4'd2, 32'h2);
        nextCycle();
        sampleCycle();
        checkVal("rst_we", 64'(ram_we), 64'd0);
        checkVal("rst_busy", 64'(init_busy), 64'd1);
        checkVal("rst_drop", 64'(drop_pulse), 64'd0);
        checkVal("rst_count", 64'(queue_count), 64'd0);
        nextCycle();
        rst = 1'b1;

        // Clear sequence with a request dropped in its first cycle.
        initPhase(2'b11);
        runCycle(2'b00, 0, 0, 0, 0, 0, 1'b0);

        // Bank conflict defers port 1, drained next cycle.
        expWrite(0, 4, 32'hA4);
        runCycle(2'b11, 4, 32'hA4, 6, 32'hA6, 0, 1'b0);
        expWrite(0, 6, 32'hA6);
        runCycle(2'b00, 0, 0, 0, 0, 1, 1'b0);

        // Same index as draining head: old data first, new request queued.
        expWrite(0, 0, 32'hD0);
        runCycle(2'b11, 0, 32'hD0, 2, 32'hD2, 0, 1'b0);
        expWrite(0, 2, 32'hD2);
        runCycle(2'b01, 2, 32'hB, 0, 0, 1, 1'b0);
        expWrite(0, 2, 32'hB);
        runCycle(2'b00, 0, 0, 0, 0, 1, 1'b0);

        // Fill the FIFO with bank-0 entries, then overflow by one.
        expWrite(0, 8, 32'hE8);
        runCycle(2'b11, 8, 32'hE8, 10, 32'hEA, 0, 1'b0);
        expWrite(0, 10, 32'hEA);
        runCycle(2'b11, 12, 32'hEC, 14, 32'hEE, 1, 1'b0);
        expWrite(0, 12, 32'hEC);
        runCycle(2'b11, 4, 32'hF4, 6, 32'hF6, 2, 1'b0);
        expWrite(0, 14, 32'hEE);
        runCycle(2'b11, 0, 32'hF0, 2, 32'hF2, 3, 1'b0);
        expWrite(0, 4, 32'hF4);
        runCycle(2'b11, 8, 32'h68, 10, 32'h6A, 4, 1'b1);
        // Bank-1 request goes out on port 1 beside the bank-0 drain.
        expWrite(0, 6, 32'hF6);
        expWrite(1, 5, 32'h45);
        runCycle(2'b01, 5, 32'h45, 0, 0, 4, 1'b0);

        // Restart the clear with three entries queued; two are lost.
        init_start = 1'b1;
        expWrite(0, 0, 32'hF0);
        runCycle(2'b00, 0, 0, 0, 0, 3, 1'b0);
        init_start = 1'b0;
        initPhase(2'b00);
        runCycle(2'b00, 0, 0, 0, 0, 0, 1'b0);

        // Request matching a resident entry blocked behind the head.
        expWrite(0, 2, 32'h22);
        runCycle(2'b11, 2, 32'h22, 4, 32'h44, 0, 1'b0);
        expWrite(0, 4, 32'h44);
        runCycle(2'b11, 6, 32'h66, 8, 32'h1, 1, 1'b0);
        expWrite(0, 6, 32'h66);
        runCycle(2'b01, 8, 32'h2, 0, 0, 2, 1'b0);
`ifdef BTB_WRITE_ARBITER_COALESCE_EN
        expWrite(0, 8, 32'h2);
        runCycle(2'b00, 0, 0, 0, 0, 1, 1'b0);
        runCycle(2'b00, 0, 0, 0, 0, 0, 1'b0);
`else
        expWrite(0, 8, 32'h1);
        runCycle(2'b00, 0, 0, 0, 0, 2, 1'b0);
        expWrite(0, 8, 32'h2);
        runCycle(2'b00, 0, 0, 0, 0, 1, 1'b0);
`endif
        runCycle(2'b00, 0, 0, 0, 0, 0, 1'b0);

        checkVal("writes_left", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
